cic_3_interpolator: RTL and testbench

Pipelined interpolating Cascaded Integrator-Comb filter of order 3, the transmit-side counterpart of the order-3 decimating CIC. It takes samples at the low rate, marked by `en_in`, through three comb stages and zero-stuffs them by `R`. Three integrators then run at the high rate, marked by `en_out`. It sits between the baseband sample source and the high-rate modulator/DAC path, and flags rate violations between the two enables.

---
 rtl/cic_pkg.sv | 11 +
 rtl/cic_rate_monitor.sv | 66 ++++++
 rtl/cic_3_interpolator.sv | 100 ++++++++++
 tb/tb_cic_3_interpolator.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// Shared CIC definitions: filter order and the bit-growth helper used by the interpolator and decimator.
package cic_pkg;

  localparam int CIC_ORDER = 3;

  // Interpolator output width: growth of R**(N-1) over the input width.
  function automatic int cic_interp_width(input int width, input int R);
    return width + $clog2(R ** (CIC_ORDER - 1));
  endfunction

endpackage

// File: rtl/cic_rate_monitor.sv
// Zero-stuff control for the CIC interpolator: tracks an un-injected comb sample and flags rate violations.
// Latency: inject_o is combinational from the current pending state; flags register on the detecting edge.
// Backpressure: none; enables are external, so violations are only reported through sticky flags.
module cic_rate_monitor #(
  parameter int R = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en_in_i,
  input  logic en_out_i,
  output logic inject_o,
  output logic overrun_o,
  output logic underrun_o
);

  localparam int              PW        = $clog2(R + 1);
  localparam logic [PW-1:0]   PHASE_MAX = PW'(R);
  localparam logic [PW-1:0]   PHASE_ONE = PW'(1);
  localparam logic [PW-1:0]   PHASE_NIL = '0;

  logic          pending_q,  pending_d;
  logic [PW-1:0] phase_q,    phase_d;
  logic          overrun_q,  overrun_d;
  logic          underrun_q, underrun_d;

  assign inject_o   = pending_q & en_out_i;
  assign overrun_o  = overrun_q;
  assign underrun_o = underrun_q;

  always_comb begin
    pending_d  = en_in_i | (pending_q & ~en_out_i);
    phase_d    = phase_q;
    overrun_d  = overrun_q;
    underrun_d = underrun_q;

    // Phase 0 means nothing injected since reset, so a starved slot there is not an underrun.
    if (en_out_i) begin
      if (pending_q) begin
        phase_d = PHASE_ONE;
      end else if (phase_q == PHASE_MAX) begin
        underrun_d = 1'b1;
      end else if (phase_q != PHASE_NIL) begin
        phase_d = phase_q + PHASE_ONE;
      end
    end

    if (en_in_i && pending_q && !en_out_i) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q  <= 1'b0;
      phase_q    <= PHASE_NIL;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      phase_q    <= phase_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

endmodule

// File: rtl/cic_3_interpolator.sv
// Order-3 interpolating CIC: pipelined combs at the en_in rate, zero-stuff by R, integrators at the en_out rate.
// Latency: sample reaches c2 two en_in edges after capture, then out two en_out edges after injection.
// Backpressure: none; rate mismatches between the enables raise sticky overrun/underrun flags.
module cic_3_interpolator
  import cic_pkg::*;
#(
  parameter int R     = 4,
  parameter int width = 8,
  localparam int OW   = cic_interp_width(width, R)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en_in,
  input  logic                 en_out,
  input  logic signed [width-1:0] in,
  output logic signed [OW-1:0] out,
  output logic                 overrun,
  output logic                 underrun
);

  logic signed [OW-1:0] in_ext;
  logic signed [OW-1:0] s_dat;
  logic                 inject;

  logic signed [OW-1:0] d0_q, d0_d, d1_q, d1_d, d2_q, d2_d;
  logic signed [OW-1:0] c0_q, c0_d, c1_q, c1_d, c2_q, c2_d;
  logic signed [OW-1:0] i0_q, i0_d, i1_q, i1_d, i2_q, i2_d;

  assign in_ext = {{(OW - width){in[width-1]}}, in};

  cic_rate_monitor #(
    .R (R)
  ) u_rate_monitor (
    .clk        (clk),
    .reset      (reset),
    .en_in_i    (en_in),
    .en_out_i   (en_out),
    .inject_o   (inject),
    .overrun_o  (overrun),
    .underrun_o (underrun)
  );

  // Coincident enables inject the old c2 while the combs load the next one.
  assign s_dat = inject ? c2_q : '0;

  always_comb begin
    d0_d = d0_q;
    d1_d = d1_q;
    d2_d = d2_q;
    c0_d = c0_q;
    c1_d = c1_q;
    c2_d = c2_q;
    i0_d = i0_q;
    i1_d = i1_q;
    i2_d = i2_q;

    if (en_in) begin
      c0_d = in_ext - d0_q;
      d0_d = in_ext;
      c1_d = c0_q - d1_q;
      d1_d = c0_q;
      c2_d = c1_q - d2_q;
      d2_d = c1_q;
    end

    // Modulo-2^OW wrap is intended; the final sum always fits in OW bits.
    if (en_out) begin
      i0_d = s_dat + i0_q;
      i1_d = i0_q + i1_q;
      i2_d = i1_q + i2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d0_q <= '0;
      d1_q <= '0;
      d2_q <= '0;
      c0_q <= '0;
      c1_q <= '0;
      c2_q <= '0;
      i0_q <= '0;
      i1_q <= '0;
      i2_q <= '0;
    end else begin
      d0_q <= d0_d;
      d1_q <= d1_d;
      d2_q <= d2_d;
      c0_q <= c0_d;
      c1_q <= c1_d;
      c2_q <= c2_d;
      i0_q <= i0_d;
      i1_q <= i1_d;
      i2_q <= i2_d;
    end
  end

  assign out = i2_q;

endmodule

// File: tb/tb_cic_3_interpolator.sv
// Bench for three interpolator instances (R = 2, 4, 8; width 8) against a rate-level reference model.
// Latency: compares every cycle at negedge against the model prediction for that cycle.
// Backpressure: none; enables are driven directly by the stimulus.
`timescale 1ns/1ps
module tb_cic_3_interpolator;

    localparam int NI = 3;

    typedef struct {
        longint out;
        bit     ov;
        bit     un;
        bit     is_const;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst [NI];
    logic              ei  [NI];
    logic              eo  [NI];
    logic signed [7:0] din [NI];
    logic              ov  [NI];
    logic              un  [NI];
    logic signed [9:0]  out0;
    logic signed [11:0] out1;
    logic signed [13:0] out2;

    cic_3_interpolator #(.R(2), .width(8)) u_r2 (
        .clk(clk), .reset(rst[0]), .en_in(ei[0]), .en_out(eo[0]), .in(din[0]),
        .out(out0), .overrun(ov[0]), .underrun(un[0]));
    cic_3_interpolator #(.R(4), .width(8)) u_r4 (
        .clk(clk), .reset(rst[1]), .en_in(ei[1]), .en_out(eo[1]), .in(din[1]),
        .out(out1), .overrun(ov[1]), .underrun(un[1]));
    cic_3_interpolator #(.R(8), .width(8)) u_r8 (
        .clk(clk), .reset(rst[2]), .en_in(ei[2]), .en_out(eo[2]), .in(din[2]),
        .out(out2), .overrun(ov[2]), .underrun(un[2]));

    // Reference state: history of accepted low-rate samples (newest first) and
    // unbounded running sums of the zero-stuffed stream; wrap is applied only at compare.
    longint hist [NI][6];
    longint acc0 [NI];
    longint acc1 [NI];
    longint acc2 [NI];
    bit     pend [NI];
    int     phase[NI];
    bit     mov  [NI];
    bit     mun  [NI];

    exp_t   expq [NI][$];
    int     abs_n = -1;
    longint abs_v = 0;

    int vectors = 0;
    int misc    = 0;
    bit done    = 1'b0;

    function automatic int r_of(input int n);
        return (n == 0) ? 2 : ((n == 1) ? 4 : 8);
    endfunction

    function automatic int ow_of(input int n);
        return 8 + $clog2(r_of(n) * r_of(n));
    endfunction

    function automatic longint sext(input longint v, input int ow);
        return (v <<< (64 - ow)) >>> (64 - ow);
    endfunction

    function automatic longint dut_out(input int n);
        if (n == 0) return longint'(out0);
        if (n == 1) return longint'(out1);
        return longint'(out2);
    endfunction

    function automatic logic signed [7:0] rnd8();
        logic [31:0] r;
        r = $urandom;
        return r[7:0];
    endfunction

    // Third difference of the input, delayed by the two-deep comb pipeline.
    function automatic longint comb_out(input int n);
        return hist[n][2] - 3 * hist[n][3] + 3 * hist[n][4] - hist[n][5];
    endfunction

    task automatic cyc();
        exp_t e;
        for (int n = 0; n < NI; n++) begin
            bit     inj;
            longint s;
            longint a0;
            longint a1;
            if (rst[n] === 1'b1) begin
                for (int k = 0; k < 6; k++) hist[n][k] = 0;
                acc0[n] = 0; acc1[n] = 0; acc2[n] = 0;
                pend[n] = 0; phase[n] = 0; mov[n] = 0; mun[n] = 0;
            end else begin
                inj = pend[n] && (eo[n] === 1'b1);
                s   = inj ? comb_out(n) : 0;
                if (ei[n] === 1'b1 && pend[n] && eo[n] !== 1'b1) mov[n] = 1;
                if (eo[n] === 1'b1) begin
                    if (inj) phase[n] = 1;
                    else if (phase[n] == r_of(n)) mun[n] = 1;
                    else if (phase[n] != 0) phase[n] = phase[n] + 1;
                    a0 = acc0[n];
                    a1 = acc1[n];
                    acc0[n] = a0 + s;
                    acc1[n] = a1 + a0;
                    acc2[n] = acc2[n] + a1;
                end
                pend[n] = (ei[n] === 1'b1) || (pend[n] && eo[n] !== 1'b1);
                if (ei[n] === 1'b1) begin
                    for (int k = 5; k > 0; k--) hist[n][k] = hist[n][k-1];
                    hist[n][0] = longint'(din[n]);
                end
            end
            e.is_const = (n == abs_n);
            e.out      = e.is_const ? abs_v : sext(acc2[n], ow_of(n));
            e.ov       = mov[n];
            e.un       = mun[n];
            expq[n].push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        for (int n = 0; n < NI; n++) begin
            rst[n] = 1'b0;
            ei[n]  = 1'b0;
            eo[n]  = 1'b0;
        end
        abs_n = -1;
    endtask

    // Direct reset-state check: out and both flags must read zero the cycle after reset.
    task automatic check_reset(input int n);
        vectors++;
        if (dut_out(n) != 0 || ov[n] !== 1'b0 || un[n] !== 1'b0) begin
            misc++;
            $display("FAIL r%0d reset @%0t: got out=%0d ov=%b un=%b, required out=0 ov=0 un=0",
                     r_of(n), $time, dut_out(n), ov[n], un[n]);
        end
    endtask

    // Nominal rate: en_out every cycle, en_in once per R cycles at the given offset.
    // mode 0 = constant v, 1 = alternating +/-127, 2 = random; optional constant check on the last 8 cycles.
    task automatic run(input int n, input int ns, input int off, input int mode,
                       input logic signed [7:0] v, input bit chk_tail, input longint tail);
        int r;
        int cycles;
        r = r_of(n);
        cycles = ns * r;
        for (int c = 0; c < cycles; c++) begin
            idle();
            eo[n] = 1'b1;
            ei[n] = ((c % r) == off);
            if (mode == 0)      din[n] = v;
            else if (mode == 1) din[n] = ((c / r) % 2 == 0) ? 8'sd127 : -8'sd127;
            else                din[n] = rnd8();
            if (chk_tail && c >= cycles - 8) begin
                abs_n = n;
                abs_v = tail;
            end
            cyc();
        end
        idle();
    endtask

    task automatic impulse_r2();
        longint imp [4];
        imp = '{1, 3, 3, 1};
        idle();
        rst[0] = 1'b1; ei[0] = 1'b1; eo[0] = 1'b1; din[0] = rnd8();
        abs_n = 0; abs_v = 0;
        cyc();
        check_reset(0);
        for (int t = 0; t < 20; t++) begin
            idle();
            eo[0]  = 1'b1;
            ei[0]  = ((t % 2) == 0);
            din[0] = (t == 0) ? 8'sd1 : 8'sd0;
            abs_n  = 0;
            abs_v  = (t >= 7 && t <= 10) ? imp[t-7] : 0;
            cyc();
        end
        idle();
    endtask

    always @(negedge clk) begin
        for (int n = 0; n < NI; n++) begin
            if (expq[n].size() != 0) begin
                exp_t   e;
                longint got;
                e   = expq[n].pop_front();
                got = dut_out(n);
                vectors++;
                if (got != e.out || ov[n] !== e.ov || un[n] !== e.un) begin
                    misc++;
                    $display("FAIL r%0d%s @%0t: got out=%0d ov=%b un=%b, required out=%0d ov=%b un=%b",
                             r_of(n), e.is_const ? " const" : " model", $time, got, ov[n], un[n],
                             e.out, e.ov, e.un);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        if (!done) begin
            $display("FAIL timeout: stimulus did not complete within the wait limit");
            $finish;
        end
    end

    initial begin
        for (int n = 0; n < NI; n++) din[n] = '0;
        idle();
        for (int n = 0; n < NI; n++) rst[n] = 1'b1;
        cyc();
        cyc();
        for (int n = 0; n < NI; n++) check_reset(n);

        // Impulse on R=2, then random data, mid-stream reset, and a repeat of the impulse.
        impulse_r2();
        run(0, 8, 0, 2, 0, 1'b0, 0);
        impulse_r2();

        // DC gain R^2 at R=4 for a positive and the most negative input.
        idle(); rst[1] = 1'b1; cyc();
        check_reset(1);
        run(1, 40, 1, 0, 8'sd100, 1'b1, 1600);
        run(1, 40, 1, 0, -8'sd128, 1'b1, -2048);

        // Overrun: two en_in edges with no en_out between, after some random data.
        idle(); rst[1] = 1'b1; cyc();
        check_reset(1);
        run(1, 6, 0, 2, 0, 1'b0, 0);
        idle(); ei[1] = 1'b1; din[1] = rnd8(); cyc();
        idle(); cyc();
        idle(); ei[1] = 1'b1; din[1] = rnd8(); cyc();
        idle(); eo[1] = 1'b1; cyc();
        run(1, 4, 0, 2, 0, 1'b0, 0);

        // Underrun: en_in stops while en_out keeps running.
        idle(); rst[1] = 1'b1; cyc();
        check_reset(1);
        run(1, 5, 2, 2, 0, 1'b0, 0);
        for (int c = 0; c < 12; c++) begin
            idle(); eo[1] = 1'b1; cyc();
        end

        // Integrator wrap at R=8 with alternating full-scale input, then random data.
        idle(); rst[2] = 1'b1; cyc();
        check_reset(2);
        run(2, 1000, 3, 1, 0, 1'b0, 0);
        run(2, 100, 0, 2, 0, 1'b0, 0);

        // Random enables and data on all instances with occasional resets.
        for (int c = 0; c < 1500; c++) begin
            idle();
            for (int n = 0; n < NI; n++) begin
                ei[n]  = ($urandom_range(0, 4) == 0);
                eo[n]  = ($urandom_range(0, 1) == 1);
                rst[n] = ($urandom_range(0, 199) == 0);
                din[n] = rnd8();
            end
            cyc();
        end

        idle();
        repeat (3) @(posedge clk);
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
        if (misc != 0) $display("FAIL: %0d miscompares", misc);
        else           $display("PASS");
        $finish;
    end

endmodule
